// File: rtl/apu_pulse_regif.sv
// APU pulse-channel register file ($4000-$4007, $4015, $4017) with frame sequencer.
// Define APU_PULSE2_EN to enable the pulse-2 registers and strobes.
module apu_pulse_regif #(
  parameter int unsigned CLKS_PER_STEP = 7457
) (
  input  logic       cpu_clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [4:0] addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic [7:0] p1_byte0,
  output logic [7:0] p1_byte1,
  output logic [7:0] p1_byte2,
  output logic [7:0] p1_byte3,
  output logic [7:0] p2_byte0,
  output logic [7:0] p2_byte1,
  output logic [7:0] p2_byte2,
  output logic [7:0] p2_byte3,
  output logic       p1_restart,
  output logic       p2_restart,
  output logic       p1_sweep_reload,
  output logic       p2_sweep_reload,
  output logic [1:0] ch_enable,
  output logic       stepSel,
  output logic       enableIntr,
  output logic       clk_qframe,
  output logic       clk_hframe,
  output logic       frame_irq
);

`ifdef APU_PULSE2_EN
  localparam logic P2_EN = 1'b1;
`else
  localparam logic P2_EN = 1'b0;
`endif

  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_STEP - 32'd1);

  logic [3:0][7:0] p1_q, p1_d, p2_q, p2_d;
  logic            p1_restart_q, p1_restart_d, p2_restart_q, p2_restart_d;
  logic            p1_sweep_q, p1_sweep_d, p2_sweep_q, p2_sweep_d;
  logic [1:0]      ch_en_q, ch_en_d;
  logic            step_sel_q, step_sel_d, irq_en_q, irq_en_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      step_q, step_d, last_step_s;
  logic            qframe_q, qframe_d, hframe_q, hframe_d, irq_q, irq_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            wr_p1_s, wr_p2_s, wr_15_s, wr_17_s, rd_15_s, wrap_s, irq_set_s;

  // Register decode, byte/control register updates, strobes and read mux.
  always_comb begin
    wr_p1_s    = wr_en && (addr[4:2] == 3'b000);
    wr_p2_s    = P2_EN && wr_en && (addr[4:2] == 3'b001);
    wr_15_s    = wr_en && (addr == 5'h15);
    wr_17_s    = wr_en && (addr == 5'h17);
    rd_15_s    = rd_en && (addr == 5'h15);
    p1_d       = p1_q;
    p2_d       = p2_q;
    ch_en_d    = ch_en_q;
    step_sel_d = step_sel_q;
    irq_en_d   = irq_en_q;
    rd_data_d  = rd_data_q;
    if (wr_p1_s) begin
      p1_d[addr[1:0]] = wr_data;
    end else begin
      p1_d = p1_q;
    end
    if (wr_p2_s) begin
      p2_d[addr[1:0]] = wr_data;
    end else begin
      p2_d = p2_q;
    end
    p1_restart_d = wr_p1_s && (addr[1:0] == 2'd3);
    p1_sweep_d   = wr_p1_s && (addr[1:0] == 2'd1);
    p2_restart_d = wr_p2_s && (addr[1:0] == 2'd3);
    p2_sweep_d   = wr_p2_s && (addr[1:0] == 2'd1);
    if (wr_15_s) begin
      ch_en_d = {wr_data[1] & P2_EN, wr_data[0]};
    end else begin
      ch_en_d = ch_en_q;
    end
    if (wr_17_s) begin
      step_sel_d = wr_data[7];
      irq_en_d   = ~wr_data[6];
    end else begin
      step_sel_d = step_sel_q;
      irq_en_d   = irq_en_q;
    end
    if (rd_en) begin
      if (rd_15_s) begin
        rd_data_d = {1'b0, irq_q, 4'b0000, ch_en_q};
      end else begin
        rd_data_d = 8'h00;
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Frame divider, step counter, tick generation and IRQ flag.
  always_comb begin
    wrap_s      = (div_q == DIV_LAST);
    last_step_s = step_sel_q ? 3'd5 : 3'd4;
    div_d       = div_q + 16'd1;
    step_d      = step_q;
    qframe_d    = 1'b0;
    hframe_d    = 1'b0;
    irq_set_s   = 1'b0;
    // A $4017 write restarts the sequence and overrides a coincident wrap.
    if (wr_17_s) begin
      div_d    = 16'd0;
      step_d   = 3'd0;
      qframe_d = wr_data[7];
      hframe_d = wr_data[7];
    end else if (wrap_s) begin
      div_d  = 16'd0;
      step_d = (step_q == last_step_s) ? 3'd1 : (step_q + 3'd1);
      case (step_d)
        3'd1, 3'd3: qframe_d = 1'b1;
        3'd2, 3'd5: begin
          qframe_d = 1'b1;
          hframe_d = 1'b1;
        end
        3'd4: begin
          if (!step_sel_q) begin
            qframe_d  = 1'b1;
            hframe_d  = 1'b1;
            irq_set_s = irq_en_q;
          end else begin
            qframe_d = 1'b0;
            hframe_d = 1'b0;
          end
        end
        default: begin
          qframe_d = 1'b0;
          hframe_d = 1'b0;
        end
      endcase
    end else begin
      div_d  = div_q + 16'd1;
      step_d = step_q;
    end
    if (irq_set_s) begin
      irq_d = 1'b1;
    end else if (rd_15_s || (wr_17_s && wr_data[6])) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      p1_q         <= '0;
      p2_q         <= '0;
      p1_restart_q <= 1'b0;
      p2_restart_q <= 1'b0;
      p1_sweep_q   <= 1'b0;
      p2_sweep_q   <= 1'b0;
      ch_en_q      <= 2'b00;
      step_sel_q   <= 1'b0;
      irq_en_q     <= 1'b1;
      div_q        <= 16'd0;
      step_q       <= 3'd0;
      qframe_q     <= 1'b0;
      hframe_q     <= 1'b0;
      irq_q        <= 1'b0;
      rd_data_q    <= 8'h00;
    end else begin
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p1_restart_q <= p1_restart_d;
      p2_restart_q <= p2_restart_d;
      p1_sweep_q   <= p1_sweep_d;
      p2_sweep_q   <= p2_sweep_d;
      ch_en_q      <= ch_en_d;
      step_sel_q   <= step_sel_d;
      irq_en_q     <= irq_en_d;
      div_q        <= div_d;
      step_q       <= step_d;
      qframe_q     <= qframe_d;
      hframe_q     <= hframe_d;
      irq_q        <= irq_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign p1_byte0        = p1_q[0];
  assign p1_byte1        = p1_q[1];
  assign p1_byte2        = p1_q[2];
  assign p1_byte3        = p1_q[3];
  assign p2_byte0        = p2_q[0];
  assign p2_byte1        = p2_q[1];
  assign p2_byte2        = p2_q[2];
  assign p2_byte3        = p2_q[3];
  assign p1_restart      = p1_restart_q;
  assign p2_restart      = p2_restart_q;
  assign p1_sweep_reload = p1_sweep_q;
  assign p2_sweep_reload = p2_sweep_q;
  assign ch_enable       = ch_en_q;
  assign stepSel         = step_sel_q;
  assign enableIntr      = irq_en_q;
  assign clk_qframe      = qframe_q;
  assign clk_hframe      = hframe_q;
  assign frame_irq       = irq_q;
  assign rd_data         = rd_data_q;

endmodule

// File: tb/tb_apu_pulse_regif.sv
// Directed scoreboard bench for apu_pulse_regif with CLKS_PER_STEP = 4.
module tb_apu_pulse_regif;

`ifdef APU_PULSE2_EN
  localparam logic [1:0] CH_EXP = 2'b11;
  localparam logic       P2     = 1'b1;
`else
  localparam logic [1:0] CH_EXP = 2'b01;
  localparam logic       P2     = 1'b0;
`endif

  logic       cpu_clk = 1'b0;
  logic       rstn, wr_en, rd_en;
  logic [4:0] addr;
  logic [7:0] wr_data, rd_data;
  logic [7:0] p1_byte0, p1_byte1, p1_byte2, p1_byte3;
  logic [7:0] p2_byte0, p2_byte1, p2_byte2, p2_byte3;
  logic       p1_restart, p2_restart, p1_sweep_reload, p2_sweep_reload;
  logic [1:0] ch_enable;
  logic       stepSel, enableIntr, clk_qframe, clk_hframe, frame_irq;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   test_cnt = 0;
  int   fail_cnt = 0;

  apu_pulse_regif #(.CLKS_PER_STEP(4)) dut (
    .cpu_clk(cpu_clk), .rstn(rstn), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data),
    .p1_byte0(p1_byte0), .p1_byte1(p1_byte1), .p1_byte2(p1_byte2), .p1_byte3(p1_byte3),
    .p2_byte0(p2_byte0), .p2_byte1(p2_byte1), .p2_byte2(p2_byte2), .p2_byte3(p2_byte3),
    .p1_restart(p1_restart), .p2_restart(p2_restart),
    .p1_sweep_reload(p1_sweep_reload), .p2_sweep_reload(p2_sweep_reload),
    .ch_enable(ch_enable), .stepSel(stepSel), .enableIntr(enableIntr),
    .clk_qframe(clk_qframe), .clk_hframe(clk_hframe), .frame_irq(frame_irq)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [7:0] obs(input string tag);
    if (tag == "p1_byte0") return p1_byte0;
    else if (tag == "p1_byte1") return p1_byte1;
    else if (tag == "p1_byte2") return p1_byte2;
    else if (tag == "p1_byte3") return p1_byte3;
    else if (tag == "p2_byte0") return p2_byte0;
    else if (tag == "p1_restart") return {7'd0, p1_restart};
    else if (tag == "p1_sweep") return {7'd0, p1_sweep_reload};
    else if (tag == "p2_restart") return {7'd0, p2_restart};
    else if (tag == "qframe") return {7'd0, clk_qframe};
    else if (tag == "hframe") return {7'd0, clk_hframe};
    else if (tag == "irq") return {7'd0, frame_irq};
    else if (tag == "rd_data") return rd_data;
    else if (tag == "ch_enable") return {6'd0, ch_enable};
    else if (tag == "stepSel") return {7'd0, stepSel};
    else if (tag == "enableIntr") return {7'd0, enableIntr};
    else return 8'hxx;
  endfunction

  task automatic exp_push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic push_bit(input string tag, input logic b);
    exp_push(tag, {7'd0, b});
  endtask

  task automatic check_pending();
    exp_t       e;
    logic [7:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs(e.tag);
      test_cnt++;
      assert (o === e.exp) else begin
        fail_cnt++;
        $error("FAIL %s: observed 0x%02h expected 0x%02h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step_clk();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic r, input logic [4:0] a, input logic [7:0] d);
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
  endtask

  task automatic cycle();
    step_clk();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_pending();
  endtask

  initial begin
    int s;
    rstn = 1'b0;
    bus(1'b0, 1'b0, 5'h00, 8'h00);
    step_clk();
    step_clk();
    // Reset state
    exp_push("p1_byte0", 8'h00); exp_push("p1_byte3", 8'h00); exp_push("p2_byte0", 8'h00);
    push_bit("p1_restart", 1'b0); push_bit("qframe", 1'b0); push_bit("hframe", 1'b0);
    push_bit("irq", 1'b0); exp_push("rd_data", 8'h00); exp_push("ch_enable", 8'h00);
    push_bit("stepSel", 1'b0); push_bit("enableIntr", 1'b1);
    check_pending();
    rstn = 1'b1;

    // 4-step sequence from reset release: q every 4, h every 8, irq at 16
    for (int k = 1; k <= 20; k++) begin
      push_bit("qframe", (k % 4) == 0);
      push_bit("hframe", (k % 8) == 0);
      push_bit("irq", k >= 16);
      cycle();
    end

    // k=21: enable channels; k=22: status read clears irq
    bus(1'b1, 1'b0, 5'h15, 8'h03);
    exp_push("ch_enable", {6'd0, CH_EXP});
    cycle();
    bus(1'b0, 1'b1, 5'h15, 8'h00);
    exp_push("rd_data", {1'b0, 1'b1, 4'b0000, CH_EXP});
    push_bit("irq", 1'b0);
    cycle();
    for (int k = 23; k <= 31; k++) cycle();
    // k=32: read coincides with step-4 irq set; set wins
    bus(1'b0, 1'b1, 5'h15, 8'h00);
    exp_push("rd_data", {1'b0, 1'b0, 4'b0000, CH_EXP});
    push_bit("irq", 1'b1);
    push_bit("qframe", 1'b1);
    push_bit("hframe", 1'b1);
    cycle();
    bus(1'b0, 1'b1, 5'h15, 8'h00);
    exp_push("rd_data", {1'b0, 1'b1, 4'b0000, CH_EXP});
    push_bit("irq", 1'b0);
    cycle();
    bus(1'b0, 1'b1, 5'h15, 8'h00);
    exp_push("rd_data", {6'd0, CH_EXP});
    cycle();
    exp_push("rd_data", {6'd0, CH_EXP});
    cycle();
    bus(1'b0, 1'b1, 5'h16, 8'h00);
    exp_push("rd_data", 8'h00);
    cycle();

    // Pulse register writes and strobes
    bus(1'b1, 1'b0, 5'h03, 8'h20);
    exp_push("p1_byte3", 8'h20); push_bit("p1_restart", 1'b1); push_bit("p1_sweep", 1'b0);
    cycle();
    bus(1'b1, 1'b0, 5'h01, 8'h5A);
    exp_push("p1_byte1", 8'h5A); push_bit("p1_restart", 1'b0); push_bit("p1_sweep", 1'b1);
    cycle();
    push_bit("p1_restart", 1'b0); push_bit("p1_sweep", 1'b0);
    cycle();
    bus(1'b1, 1'b0, 5'h04, 8'h4F);
    exp_push("p2_byte0", P2 ? 8'h4F : 8'h00);
    cycle();
    bus(1'b1, 1'b0, 5'h07, 8'h11);
    push_bit("p2_restart", P2);
    cycle();
    bus(1'b1, 1'b0, 5'h08, 8'hFF);
    exp_push("p1_byte0", 8'h00); exp_push("p1_byte3", 8'h20);
    cycle();
    bus(1'b1, 1'b0, 5'h02, 8'h33);
    exp_push("p1_byte2", 8'h33);
    cycle();

    // $17=0x00 (also lands on a divider wrap): restart, no tick
    bus(1'b1, 1'b0, 5'h17, 8'h00);
    push_bit("qframe", 1'b0); push_bit("hframe", 1'b0);
    push_bit("stepSel", 1'b0); push_bit("enableIntr", 1'b1);
    cycle();
    for (int j = 1; j <= 16; j++) begin
      push_bit("qframe", (j % 4) == 0);
      push_bit("hframe", (j % 8) == 0);
      push_bit("irq", j >= 16);
      cycle();
    end
    // $17=0x40: inhibit clears irq and blocks further sets
    bus(1'b1, 1'b0, 5'h17, 8'h40);
    push_bit("irq", 1'b0); push_bit("enableIntr", 1'b0); push_bit("qframe", 1'b0);
    cycle();
    for (int j = 1; j <= 16; j++) begin
      push_bit("qframe", (j % 4) == 0);
      push_bit("irq", 1'b0);
      cycle();
    end

    // $17=0x80: immediate q+h, then 5-step pattern, no irq
    bus(1'b1, 1'b0, 5'h17, 8'h80);
    push_bit("qframe", 1'b1); push_bit("hframe", 1'b1);
    push_bit("stepSel", 1'b1); push_bit("enableIntr", 1'b1);
    cycle();
    for (int j = 1; j <= 40; j++) begin
      s = ((j % 4) == 0) ? (((j / 4) - 1) % 5) + 1 : 0;
      push_bit("qframe", (s == 1) || (s == 2) || (s == 3) || (s == 5));
      push_bit("hframe", (s == 2) || (s == 5));
      push_bit("irq", 1'b0);
      cycle();
    end
    for (int j = 41; j <= 43; j++) begin
      push_bit("qframe", 1'b0);
      cycle();
    end
    // $17 write on the wrap edge suppresses the step-1 tick
    bus(1'b1, 1'b0, 5'h17, 8'h00);
    push_bit("qframe", 1'b0); push_bit("hframe", 1'b0); push_bit("stepSel", 1'b0);
    cycle();
    for (int j = 1; j <= 4; j++) begin
      push_bit("qframe", j == 4);
      push_bit("hframe", 1'b0);
      cycle();
    end

    // Reset asserted mid-pulse
    bus(1'b1, 1'b0, 5'h00, 8'h4F);
    exp_push("p1_byte0", 8'h4F);
    cycle();
    bus(1'b1, 1'b0, 5'h17, 8'hC0);
    push_bit("qframe", 1'b1); push_bit("hframe", 1'b1);
    push_bit("stepSel", 1'b1); push_bit("enableIntr", 1'b0);
    cycle();
    #2;
    rstn = 1'b0;
    #1;
    exp_push("p1_byte0", 8'h00); exp_push("p1_byte3", 8'h00);
    push_bit("qframe", 1'b0); push_bit("hframe", 1'b0);
    push_bit("stepSel", 1'b0); push_bit("enableIntr", 1'b1);
    exp_push("ch_enable", 8'h00); push_bit("irq", 1'b0);
    check_pending();
    step_clk();
    step_clk();
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_bit("qframe", k == 4);
      push_bit("hframe", 1'b0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
